soc_system_led_pwm_pio: RTL and testbench
=========================================

SOC_SYSTEM_LED_PWM_PIO -- requirements
Module: soc_system_led_pwm_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of LED outputs (legal 1..32).
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter and duty width (legal 1..16).
REQ-003 SHALL have parameter PRESC_BITS, default 16, prescaler width (legal 1..32).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port address, input, 3, Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port readdata, output, 32, read data.
REQ-011 SHALL have port out_port, output, WIDTH, LED drive.
REQ-012 SHALL have port pwm_tick, output, 1, one-cycle pulse on each PWM counter advance (debug/trigger).

Function
REQ-013 SHALL define write strobe = chipselect & ~write_n; no wait states; writes take effect at the clock edge of the strobe.
REQ-014 SHALL map registers: 0 DATA (WIDTH, R/W); 1 MODE (WIDTH, R/W, 1=PWM gated); 2 BLINK (WIDTH, R/W, 1=blink gated); 3 DUTY (PWM_BITS, R/W); 4 SET (W); 5 CLEAR (W); 6 PRESCALE (PRESC_BITS, R/W); 7 STATUS (RO, current out_port).
REQ-015 SHALL on write to 4 perform DATA <= DATA | writedata[WIDTH-1:0]; on write to 5 DATA <= DATA & ~writedata[WIDTH-1:0]; writes to 7 ignored; writedata bits above register width ignored.
REQ-016 SHALL drive readdata combinationally from address, zero-extended to 32 bits; addresses 4 and 5 read 0.
REQ-017 SHALL keep prescaler counter pcnt; pwm_tick=1 in cycles where pcnt==PRESCALE, then pcnt<=0, else pcnt<=pcnt+1; PRESCALE=0 gives pwm_tick every cycle.
REQ-018 SHALL advance PWM counter cnt (PWM_BITS) by 1 on pwm_tick, wrapping 2^PWM_BITS-1 -> 0.
REQ-019 SHALL toggle blink phase bit bph on the pwm_tick at which cnt wraps to 0.
REQ-020 SHALL compute pwm_on = (cnt < DUTY) | (DUTY == all ones); DUTY=0 means always off, DUTY=all ones always on.
REQ-021 SHALL register out_port[i] <= DATA[i] & (~MODE[i] | pwm_on) & (~BLINK[i] | bph), one cycle latency from any state change.
REQ-022 SHALL on write to PRESCALE or DUTY clear pcnt and cnt in the same edge (phase restart); bph unchanged.
REQ-023 SHALL, if PRESCALE is written lower than current pcnt, be covered by REQ-022 (no runaway count).
REQ-024 SHALL keep gating of a bit with MODE=0 and BLINK=0 identical to a plain output register (DATA written at edge N visible on out_port at edge N+1).

Reset
REQ-025 SHALL, while reset=1, asynchronously force DATA, MODE, BLINK, out_port, pcnt, cnt, bph and pwm_tick to 0, DUTY to 0, PRESCALE to 0.
REQ-026 SHALL resume counting from 0 on the first rising clk after reset deasserts; reset mid-PWM-period abandons the period with no glitch beyond forcing out_port=0.

Verification
REQ-027 SHALL test: write DATA=0xA5 at addr 0 -> out_port=0xA5 one cycle later, readdata at addr 0 and 7 = 0x000000A5.
REQ-028 SHALL test: DATA=0xF0, write 0x0C to addr 4 then 0x30 to addr 5 -> out_port 0xFC then 0xCC.
REQ-029 SHALL test: PRESCALE=0, DUTY=64, MODE=0x01, DATA=0x01 -> out_port[0] high 64 of every 256 cycles, pwm_tick every cycle.
REQ-030 SHALL test: PRESCALE=3, DUTY=0 and DUTY=0xFF with MODE=0xFF -> out_port constant 0x00 / DATA; pwm_tick every 4th cycle.
REQ-031 SHALL test: BLINK=0x80, DATA=0x80, PRESCALE=0 -> out_port[7] toggles every 256 cycles; writing DUTY mid-period restarts cnt at 0.
REQ-032 SHALL test: reset asserted asynchronously mid-PWM with DATA=0xFF -> out_port=0x00 immediately, all registers read 0 after release.

Source files
------------

// File: rtl/soc_system_led_pwm_pio.sv
// Avalon-MM LED PIO with per-bit PWM and blink gating.
// A prescaler paces a shared PWM counter; its wrap toggles a common blink phase.
module soc_system_led_pwm_pio #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PRESC_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pwm_tick
);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrMode   = 3'd1;
  localparam logic [2:0] AddrBlink  = 3'd2;
  localparam logic [2:0] AddrDuty   = 3'd3;
  localparam logic [2:0] AddrSet    = 3'd4;
  localparam logic [2:0] AddrClear  = 3'd5;
  localparam logic [2:0] AddrPresc  = 3'd6;
  localparam logic [2:0] AddrStatus = 3'd7;

  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mode_q, mode_d;
  logic [WIDTH-1:0]      blink_q, blink_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [PRESC_BITS-1:0] pcnt_q, pcnt_d;
  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic                  bph_q, bph_d;
  logic [WIDTH-1:0]      out_q, out_d;

  logic             wr;
  logic             restart;
  logic             tick;
  logic             pwm_on;
  logic [WIDTH-1:0] wr_bits;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_bits   = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  // Retiming the PWM phase on DUTY/PRESCALE writes also keeps pcnt from
  // running past a newly lowered terminal count.
  assign restart = wr & ((address == AddrDuty) | (address == AddrPresc));
  assign tick    = (pcnt_q == presc_q);
  // While reset holds pcnt == PRESCALE == 0, so the strobe is masked explicitly.
  assign pwm_tick = tick & ~reset;

  assign pwm_on = (cnt_q < duty_q) | (&duty_q);

  always_comb begin
    data_d  = data_q;
    mode_d  = mode_q;
    blink_d = blink_q;
    duty_d  = duty_q;
    presc_d = presc_q;
    if (wr) begin
      case (address)
        AddrData:  data_d  = wr_bits;
        AddrMode:  mode_d  = wr_bits;
        AddrBlink: blink_d = wr_bits;
        AddrDuty:  duty_d  = writedata[PWM_BITS-1:0];
        AddrSet:   data_d  = data_q | wr_bits;
        AddrClear: data_d  = data_q & ~wr_bits;
        AddrPresc: presc_d = writedata[PRESC_BITS-1:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    pcnt_d = pcnt_q + PRESC_BITS'(1);
    cnt_d  = cnt_q;
    bph_d  = bph_q;
    if (restart) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (tick) begin
      pcnt_d = '0;
      cnt_d  = cnt_q + PWM_BITS'(1);
      if (&cnt_q) begin
        bph_d = ~bph_q;
      end
    end
  end

  always_comb begin
    out_d = data_q & (~mode_q | {WIDTH{pwm_on}}) & (~blink_q | {WIDTH{bph_q}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      mode_q  <= '0;
      blink_q <= '0;
      duty_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      bph_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      data_q  <= data_d;
      mode_q  <= mode_d;
      blink_q <= blink_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      bph_q   <= bph_d;
      out_q   <= out_d;
    end
  end

  assign out_port = out_q;

  always_comb begin
    readdata = '0;
    case (address)
      AddrData:   readdata[WIDTH-1:0]      = data_q;
      AddrMode:   readdata[WIDTH-1:0]      = mode_q;
      AddrBlink:  readdata[WIDTH-1:0]      = blink_q;
      AddrDuty:   readdata[PWM_BITS-1:0]   = duty_q;
      AddrPresc:  readdata[PRESC_BITS-1:0] = presc_q;
      AddrStatus: readdata[WIDTH-1:0]      = out_q;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_soc_system_led_pwm_pio.sv
// Self-checking bench for soc_system_led_pwm_pio: directed scenarios plus random
// bus traffic, all compared against an integer reference model.
module tb_soc_system_led_pwm_pio;

  localparam int W       = 8;
  localparam int PWM_MAX = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   address = 3'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] out_port;
  logic         pwm_tick;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int m_data, m_mode, m_blink, m_duty, m_presc, m_pcnt, m_cnt, m_bph, m_out;

  soc_system_led_pwm_pio #(
    .WIDTH(8),
    .PWM_BITS(8),
    .PRESC_BITS(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .pwm_tick  (pwm_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_data = 0; m_mode = 0; m_blink = 0; m_duty = 0; m_presc = 0;
    m_pcnt = 0; m_cnt = 0; m_bph = 0; m_out = 0;
  endfunction

  function automatic int model_read(input int a);
    case (a)
      0: return m_data;
      1: return m_mode;
      2: return m_blink;
      3: return m_duty;
      6: return m_presc;
      7: return m_out;
      default: return 0;
    endcase
  endfunction

  // One rising edge of the reference, using the bus values present at that edge.
  function automatic void model_step();
    bit wr;
    bit on;
    int nxt;
    int wd;
    wr  = chipselect && !write_n;
    on  = (m_cnt < m_duty) || (m_duty == PWM_MAX);
    wd  = int'(writedata);
    nxt = 0;
    for (int i = 0; i < W; i++) begin
      if (m_data[i] && (!m_mode[i] || on) && (!m_blink[i] || m_bph != 0)) nxt |= (1 << i);
    end
    if (wr && (address == 3 || address == 6)) begin
      m_pcnt = 0;
      m_cnt  = 0;
    end else if (m_pcnt == m_presc) begin
      m_pcnt = 0;
      m_cnt  = (m_cnt + 1) % (PWM_MAX + 1);
      if (m_cnt == 0) m_bph = 1 - m_bph;
    end else begin
      m_pcnt = m_pcnt + 1;
    end
    if (wr) begin
      case (address)
        0: m_data  = wd & 'hFF;
        1: m_mode  = wd & 'hFF;
        2: m_blink = wd & 'hFF;
        3: m_duty  = wd & 'hFF;
        4: m_data  = m_data | (wd & 'hFF);
        5: m_data  = m_data & ~(wd & 'hFF) & 'hFF;
        6: m_presc = wd & 'hFFFF;
        default: ;
      endcase
    end
    m_out = nxt;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("out_port", 32'(out_port), m_out);
    check_eq("pwm_tick", 32'(pwm_tick), 32'(m_pcnt == m_presc));
    check_eq("readdata", readdata, model_read(int'(address)));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    int cnt_a, cnt_b, zero_bad, prev;
    logic [31:0] wd;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out", 32'(out_port), 0);
    check_eq("rst_tick", 32'(pwm_tick), 0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1 check_eq("rst_read", readdata, 0);
    end
    address = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    run(3);

    // DATA write with one cycle of output latency
    bus_write(3'd0, 32'hFFFF_FFA5);
    check_eq("a5_not_yet", 32'(out_port), 0);
    cycle();
    check_eq("a5_out", 32'(out_port), 32'hA5);
    address = 3'd0;
    #1 check_eq("a5_rd0", readdata, 32'h0000_00A5);
    address = 3'd7;
    #1 check_eq("a5_rd7", readdata, 32'h0000_00A5);

    // SET / CLEAR
    bus_write(3'd0, 32'hF0);
    bus_write(3'd4, 32'h0C);
    cycle();
    check_eq("set_out", 32'(out_port), 32'hFC);
    bus_write(3'd5, 32'h30);
    cycle();
    check_eq("clr_out", 32'(out_port), 32'hCC);
    address = 3'd4;
    #1 check_eq("rd_set", readdata, 0);
    address = 3'd5;
    #1 check_eq("rd_clr", readdata, 0);

    // PWM 64/256 with prescale 0
    bus_write(3'd6, 32'd0);
    bus_write(3'd3, 32'd64);
    bus_write(3'd1, 32'h01);
    bus_write(3'd0, 32'h01);
    run(4);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      cnt_a += int'(out_port[0]);
      cnt_b += int'(pwm_tick);
    end
    check_eq("pwm64_high", cnt_a, 64);
    check_eq("pwm64_ticks", cnt_b, 256);

    // Prescale 3, DUTY extremes
    bus_write(3'd1, 32'hFF);
    bus_write(3'd0, 32'h5A);
    bus_write(3'd6, 32'd3);
    bus_write(3'd3, 32'd0);
    run(2);
    zero_bad = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (out_port != 0) zero_bad++;
      cnt_b += int'(pwm_tick);
    end
    check_eq("duty0_const", zero_bad, 0);
    check_eq("presc3_ticks", cnt_b, 10);
    bus_write(3'd3, 32'hFF);
    run(2);
    zero_bad = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (out_port != 8'h5A) zero_bad++;
    end
    check_eq("dutyff_const", zero_bad, 0);

    // Blink on bit 7
    bus_write(3'd6, 32'd0);
    bus_write(3'd1, 32'h00);
    bus_write(3'd2, 32'h80);
    bus_write(3'd0, 32'h80);
    run(3);
    cnt_a = 0;
    prev = int'(out_port[7]);
    for (int i = 0; i < 1024; i++) begin
      cycle();
      if (int'(out_port[7]) != prev) cnt_a++;
      prev = int'(out_port[7]);
    end
    check_eq("blink_toggles", cnt_a, 4);

    // DUTY write mid-period restarts cnt
    bus_write(3'd1, 32'h01);
    bus_write(3'd0, 32'h81);
    bus_write(3'd3, 32'd16);
    run(100);
    check_eq("mid_off", 32'(out_port[0]), 0);
    bus_write(3'd3, 32'd16);
    cnt_a = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      cnt_a += int'(out_port[0]);
    end
    check_eq("restart_on", cnt_a, 16);
    cycle();
    check_eq("restart_off", 32'(out_port[0]), 0);

    // Random bus traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        wd = $urandom;
        address = 3'($urandom_range(0, 7));
        if (address == 3'd6) wd = (wd & 32'hFFFF_0000) | $urandom_range(0, 5);
        bus_write(address, wd);
      end else begin
        address = 3'($urandom_range(0, 7));
        cycle();
      end
    end

    // Asynchronous reset mid-PWM
    bus_write(3'd2, 32'h00);
    bus_write(3'd1, 32'h0F);
    bus_write(3'd0, 32'hFF);
    bus_write(3'd6, 32'd1);
    bus_write(3'd3, 32'd100);
    run(50);
    check_eq("pre_rst_out", 32'(out_port), 32'hFF);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_out", 32'(out_port), 0);
    check_eq("async_rst_tick", 32'(pwm_tick), 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1 check_eq("post_rst_read", readdata, 0);
    end
    run(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
